// File: rtl/md_sched.sv
// md_sched: issue/hazard controller for the multiply/divide datapath in the
// execute stage. Forwards each accepted request as a one-cycle start code and
// holds every further multiply/divide-class request while an operation is in flight.
// Latency: md_start/illegal/stall/req_ready are combinational in the accept cycle;
// busy is high for MUL_LAT (mult/multu) or DIV_LAT (div/divu) cycles after accept.
// Backpressure: req_ready=0 while busy; a blocked req_valid raises stall (unless flushed).
// Optional feature macro: MD_SCHED_PERF_EN (saturating 16-bit stall cycle counter).
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   req_valid       E stage holds a multiply/divide-class instruction
//   req_op[3:0]     1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo,
//                   0 no-op, 9-15 illegal
//   flush           E-stage instruction cancelled; beats req_valid
//   req_ready       request can be accepted this cycle
//   stall           freeze D/E
//   md_start[3:0]   start code to the HI/LO datapath, one cycle
//   busy            operation in flight
//   illegal         accepted request carried op 9-15
//   stall_cycles    saturating stall counter (0 when MD_SCHED_PERF_EN is undefined)
module md_sched #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic        flush,
  output logic        req_ready,
  output logic        stall,
  output logic [3:0]  md_start,
  output logic        busy,
  output logic        illegal,
  output logic [15:0] stall_cycles
);

  localparam int LAT_MAX = (1 << CNT_W) - 1;

  // A latency of 0 or one that does not fit the counter is a build error.
  if (MUL_LAT < 1 || MUL_LAT > LAT_MAX || DIV_LAT < 1 || DIV_LAT > LAT_MAX) begin : g_bad_cfg
    $error("md_sched: MUL_LAT/DIV_LAT must be in 1..2^CNT_W-1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_accept;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    req_ready   = (r_state == IDLE);
    // flush wins over req_valid: it masks acceptance and stall alike.
    w_accept    = req_valid & req_ready & ~flush;
    stall       = req_valid & ~req_ready & ~flush;
    md_start    = 4'd0;
    illegal     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_op >= 4'd1 && req_op <= 4'd8) begin
            md_start = req_op;
          end
          if (req_op >= 4'd9) begin
            illegal = 1'b1;
          end
          if (req_op == 4'd1 || req_op == 4'd2) begin
            w_state_nxt = MUL;
            w_cnt_nxt   = CNT_W'(MUL_LAT);
          end else if (req_op == 4'd3 || req_op == 4'd4) begin
            w_state_nxt = DIV;
            w_cnt_nxt   = CNT_W'(DIV_LAT);
          end
        end
      end
      MUL, DIV: begin
        // Counter is loaded with the latency, so the last busy cycle sees cnt==1.
        if (r_cnt == CNT_W'(1)) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (r_state != IDLE);

`ifdef MD_SCHED_PERF_EN
  logic [15:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 16'd0;
    end else if (stall && r_stall_cycles != 16'hFFFF) begin
      r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: hand-computed expectations, one checking task.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic        flush;
  logic        req_ready;
  logic        stall;
  logic [3:0]  md_start;
  logic        busy;
  logic        illegal;
  logic [15:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef MD_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  md_sched #(.MUL_LAT(5), .DIV_LAT(10), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_op       (req_op),
    .flush        (flush),
    .req_ready    (req_ready),
    .stall        (stall),
    .md_start     (md_start),
    .busy         (busy),
    .illegal      (illegal),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic fl);
    req_valid = v;
    req_op    = op;
    flush     = fl;
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; flush = 1'b0;
    step(); step();
    reset = 1'b0;
    drive(1'b0, 4'd0, 1'b0);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_start", md_start, 0);
    check("rst_illegal", illegal, 0);
    check("rst_stall", stall, 0);
    check("rst_stall_cycles", stall_cycles, 0);

    // cycle 2: mult accepted
    drive(1'b1, 4'd1, 1'b0);
    check("mul_start", md_start, 1);
    check("mul_ready", req_ready, 1);
    check("mul_stall", stall, 0);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("mul_busy_c3", busy, 1);
    check("mul_ready_c3", req_ready, 0);
    step();
    // cycles 4..7: div blocked behind the multiply
    drive(1'b1, 4'd3, 1'b0);
    for (int c = 4; c <= 7; c++) begin
      check("div_wait_stall", stall, 1);
      check("div_wait_start", md_start, 0);
      check("div_wait_busy", busy, 1);
      step();
    end
    // cycle 8: multiply done, div accepted
    check("c8_busy", busy, 0);
    check("c8_stall", stall, 0);
    check("c8_start", md_start, 3);
    check("c8_ready", req_ready, 1);
    step();
    // cycles 9..18: mflo held behind the divide
    drive(1'b1, 4'd6, 1'b0);
    for (int c = 9; c <= 18; c++) begin
      check("div_busy", busy, 1);
      check("mflo_ready", req_ready, 0);
      check("mflo_stall", stall, 1);
      check("mflo_start_held", md_start, 0);
      step();
    end
    check("c19_busy", busy, 0);
    check("c19_start", md_start, 6);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("mflo_no_busy", busy, 0);
    check("mflo_one_cycle", md_start, 0);
    check("perf_after_div", stall_cycles, PERF ? 14 : 0);

    // mf*/mt* back to back in IDLE
    drive(1'b1, 4'd5, 1'b0);
    check("b2b_mfhi", md_start, 5);
    step();
    drive(1'b1, 4'd7, 1'b0);
    check("b2b_mthi", md_start, 7);
    check("b2b_busy", busy, 0);
    check("b2b_stall", stall, 0);
    step();
    drive(1'b1, 4'd8, 1'b0);
    check("b2b_mtlo", md_start, 8);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("b2b_end_busy", busy, 0);
    check("b2b_end_start", md_start, 0);

    // flush in IDLE
    drive(1'b1, 4'd4, 1'b1);
    check("flush_idle_start", md_start, 0);
    check("flush_idle_stall", stall, 0);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("flush_idle_busy", busy, 0);
    check("flush_idle_ready", req_ready, 1);

    // flush while busy does not abort the divide
    drive(1'b1, 4'd4, 1'b0);
    check("divu_start", md_start, 4);
    step();
    drive(1'b1, 4'd5, 1'b0);
    check("busy_req_stall", stall, 1);
    check("busy_req_busy", busy, 1);
    step();
    drive(1'b1, 4'd5, 1'b1);
    check("busy_flush_stall", stall, 0);
    check("busy_flush_start", md_start, 0);
    check("busy_flush_busy", busy, 1);
    step();
    drive(1'b0, 4'd0, 1'b0);
    for (int k = 3; k <= 10; k++) begin
      check("divu_busy", busy, 1);
      step();
    end
    check("divu_done_busy", busy, 0);
    check("divu_done_ready", req_ready, 1);
    check("perf_after_flush", stall_cycles, PERF ? 15 : 0);

    // illegal and no-op ops
    drive(1'b1, 4'd12, 1'b0);
    check("ill12_flag", illegal, 1);
    check("ill12_start", md_start, 0);
    check("ill12_busy", busy, 0);
    step();
    drive(1'b1, 4'd0, 1'b0);
    check("nop_illegal", illegal, 0);
    check("nop_start", md_start, 0);
    check("ill_no_busy", busy, 0);
    step();
    drive(1'b1, 4'd15, 1'b0);
    check("ill15_flag", illegal, 1);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("ill_end_flag", illegal, 0);
    check("ill_end_busy", busy, 0);

    // reset in the 3rd busy cycle of a divide
    drive(1'b1, 4'd3, 1'b0);
    step();
    drive(1'b0, 4'd0, 1'b0);
    step(); step();
    check("rst_mid_busy3", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_perf", stall_cycles, 0);

    // mfhi held behind a divide: 10 stall cycles
    drive(1'b1, 4'd3, 1'b0);
    check("perf_div_start", md_start, 3);
    step();
    drive(1'b1, 4'd5, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      check("perf_mfhi_stall", stall, 1);
      step();
    end
    check("perf_mfhi_start", md_start, 5);
    check("perf_mfhi_nostall", stall, 0);
    step();
    drive(1'b0, 4'd0, 1'b0);
    check("perf_count10", stall_cycles, PERF ? 10 : 0);

    if (PERF) begin
      // 6560 divides x 10 stalls each push well past 65535
      for (int i = 0; i < 6560; i++) begin
        drive(1'b1, 4'd3, 1'b0);
        step();
        drive(1'b1, 4'd5, 1'b0);
        repeat (10) step();
      end
      drive(1'b0, 4'd0, 1'b0);
      check("perf_saturate", stall_cycles, 65535);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
